rs_error_corrector: RTL and testbench

//  Final stage of the RS(n,k) decoder. Buffers every received codeword symbol while syndrome/BM/Chien/Forney run,

---
 rtl/rs_error_corrector.sv | 205 ++++++++++++++++++++
 tb/tb_rs_error_corrector.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_error_corrector.sv
// Purpose: RS decoder final stage; buffers received symbols, replays them XORed with Forney magnitudes.
// Latency: corrected symbol 1 cycle after its err_valid; frame_done 1 cycle after corr_eof.
// Backpressure: none; writes to a full buffer are dropped (sticky overflow), reads on empty underflow.
module rs_error_corrector #(
    parameter int N     = 255,
    parameter int K     = 239,
    parameter int T     = 8,
    parameter int M     = 8,
    parameter int DEPTH = 512
) (
    input  logic         clk_in,
    input  logic         sys_rst_n,
    input  logic         rx_valid,
    input  logic         rx_sof,
    input  logic [M-1:0] rx_data,
    input  logic         err_valid,
    input  logic         err_sof,
    input  logic         err_loc,
    input  logic [M-1:0] err_mag,
    input  logic [3:0]   lambda_deg,
    output logic         corr_valid,
    output logic         corr_sof,
    output logic         corr_eof,
    output logic         corr_msg,
    output logic [M-1:0] corr_data,
    output logic         frame_done,
    output logic [3:0]   err_count,
    output logic         decode_fail,
    output logic         overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int IW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CORRECT,
        S_DONE
    } state_t;

    state_t         state;
    state_t         state_nxt;

    logic [M-1:0]   mem [DEPTH];
    logic [M-1:0]   ram_q;
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    occ;

    logic [IW-1:0]  idx;
    logic [IW-1:0]  cur_idx;
    logic [3:0]     cnt;
    logic [3:0]     deg;
    logic           uf_seen;

    logic           loc_q;
    logic [M-1:0]   mag_q;
    logic           uf_q;

    logic           take;
    logic           start;
    logic           empty;
    logic           wr_en;
    logic           rd_en;
    logic           hit;

    // Frame boundaries come only from the err side, so rx_sof is not needed.
    logic           rx_sof_unused;
    assign rx_sof_unused = rx_sof;

    assign empty = (occ == '0);
    assign wr_en = rx_valid && (occ != (AW+1)'(DEPTH));
    assign rd_en = take && !empty;
    assign hit   = err_loc && (err_mag != '0);

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        start     = 1'b0;
        case (state)
            S_IDLE: begin
                if (err_valid && err_sof) begin
                    take      = 1'b1;
                    start     = 1'b1;
                    state_nxt = S_CORRECT;
                end
            end
            S_CORRECT: begin
                if (err_valid) begin
                    take = 1'b1;
                    if (idx == IW'(N-1)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                // A new frame may start while the previous one is being reported.
                if (err_valid && err_sof) begin
                    take      = 1'b1;
                    start     = 1'b1;
                    state_nxt = S_CORRECT;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    assign cur_idx = start ? '0 : idx;

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Symbol RAM: no reset, one write port and one registered read port.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_ptr] <= rx_data;
        end
        if (rd_en) begin
            ram_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            occ      <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
            if (rx_valid && !wr_en) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx     <= '0;
            cnt     <= '0;
            deg     <= '0;
            uf_seen <= 1'b0;
        end else if (take) begin
            idx <= cur_idx + 1'b1;
            if (start) begin
                cnt     <= 4'(hit);
                deg     <= lambda_deg;
                uf_seen <= empty;
            end else begin
                if (hit && (cnt != 4'hF)) begin
                    cnt <= cnt + 1'b1;
                end
                uf_seen <= uf_seen | empty;
            end
        end
    end

    always_ff @(posedge clk_in or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            corr_valid  <= 1'b0;
            corr_sof    <= 1'b0;
            corr_eof    <= 1'b0;
            corr_msg    <= 1'b0;
            loc_q       <= 1'b0;
            mag_q       <= '0;
            uf_q        <= 1'b0;
            frame_done  <= 1'b0;
            err_count   <= '0;
            decode_fail <= 1'b0;
        end else begin
            corr_valid <= take;
            corr_sof   <= take && (cur_idx == '0);
            corr_eof   <= take && (cur_idx == IW'(N-1));
            corr_msg   <= take && (cur_idx < IW'(K));
            loc_q      <= err_loc;
            mag_q      <= err_mag;
            uf_q       <= empty;
            frame_done <= (state == S_DONE);
            if (state == S_DONE) begin
                err_count   <= cnt;
                decode_fail <= (cnt != deg) || (deg > 4'(T)) || uf_seen;
            end
        end
    end

    // Underflowed positions read nothing, so the stale RAM word is masked to zero.
    assign corr_data = (corr_valid && !uf_q) ? (ram_q ^ (loc_q ? mag_q : '0)) : '0;

endmodule

// File: tb/tb_rs_error_corrector.sv
// Bench for rs_error_corrector: directed scenarios with random symbols/errors,
// checked cycle by cycle against a queue-based reference model.
module tb_rs_error_corrector;
    localparam int N = 255;
    localparam int K = 239;

    logic       clk_in = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rx_valid = 1'b0;
    logic       rx_sof = 1'b0;
    logic [7:0] rx_data = '0;
    logic       err_valid = 1'b0;
    logic       err_sof = 1'b0;
    logic       err_loc = 1'b0;
    logic [7:0] err_mag = '0;
    logic [3:0] lambda_deg = '0;
    logic       corr_valid, corr_sof, corr_eof, corr_msg;
    logic [7:0] corr_data;
    logic       frame_done;
    logic [3:0] err_count;
    logic       decode_fail;
    logic       overflow;

    rs_error_corrector dut (
        .clk_in(clk_in), .sys_rst_n(sys_rst_n),
        .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_data(rx_data),
        .err_valid(err_valid), .err_sof(err_sof), .err_loc(err_loc),
        .err_mag(err_mag), .lambda_deg(lambda_deg),
        .corr_valid(corr_valid), .corr_sof(corr_sof), .corr_eof(corr_eof),
        .corr_msg(corr_msg), .corr_data(corr_data), .frame_done(frame_done),
        .err_count(err_count), .decode_fail(decode_fail), .overflow(overflow)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] mq[$];
    bit         m_ovf, m_in_frame, m_done, m_uf;
    int         m_pos, m_cnt, m_deg;
    logic [3:0] e_cnt;
    bit         e_fail;
    int         wcount;

    bit         loc_a[N];
    logic [7:0] mag_a[N];
    bit         loc_b[2*N];
    logic [7:0] mag_b[2*N];
    logic [3:0] lam_b[2];

    int         last_cnt;
    bit         last_fail;
    int         fd_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_ovf = 0; m_in_frame = 0; m_done = 0; m_uf = 0;
        m_pos = 0; m_cnt = 0; m_deg = 0;
        e_cnt = '0; e_fail = 0;
        wcount = 0;
    endtask

    // One clock: drive inputs, advance the model, check every output after the edge.
    task automatic step(input bit rv, input logic [7:0] rd, input bit ev, input bit es,
                        input bit el, input logic [7:0] em, input logic [3:0] ld);
        bit         take, x_cv, x_sof, x_eof, x_msg, x_fd;
        logic [7:0] x_dat;
        rx_valid = rv; rx_data = rd; rx_sof = rv && (wcount % N == 0);
        if (rv) wcount++;
        err_valid = ev; err_sof = es; err_loc = el; err_mag = em; lambda_deg = ld;

        x_fd = m_done;
        m_done = 0;
        if (x_fd) begin
            e_cnt  = 4'(m_cnt);
            e_fail = (m_cnt != m_deg) || (m_deg > 8) || m_uf;
        end
        take = ev && (m_in_frame || es);
        x_cv = take; x_sof = 0; x_eof = 0; x_msg = 0; x_dat = '0;
        if (take) begin
            if (!m_in_frame) begin
                m_in_frame = 1; m_pos = 0; m_cnt = 0; m_deg = int'(ld); m_uf = 0;
            end
            if (mq.size() == 0) begin
                m_uf = 1;
                x_dat = '0;
            end else begin
                x_dat = mq.pop_front() ^ (el ? em : 8'h00);
            end
            if (el && em != 0 && m_cnt < 15) m_cnt++;
            x_sof = (m_pos == 0);
            x_eof = (m_pos == N-1);
            x_msg = (m_pos < K);
            if (m_pos == N-1) begin
                m_in_frame = 0;
                m_done = 1;
            end else begin
                m_pos++;
            end
        end
        if (rv) begin
            if (mq.size() < 512) mq.push_back(rd);
            else m_ovf = 1;
        end

        @(posedge clk_in);
        #1;
        chk("corr_valid", corr_valid, x_cv);
        if (x_cv) begin
            chk("corr_data", corr_data, x_dat);
            chk("corr_sof", corr_sof, x_sof);
            chk("corr_eof", corr_eof, x_eof);
            chk("corr_msg", corr_msg, x_msg);
        end
        chk("frame_done", frame_done, x_fd);
        chk("err_count", err_count, e_cnt);
        chk("decode_fail", decode_fail, e_fail);
        chk("overflow", overflow, m_ovf);
        if (frame_done) begin
            last_cnt  = int'(err_count);
            last_fail = decode_fail;
            fd_seen++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0, 0, 8'h00, 4'd0);
    endtask

    task automatic write_ramp();
        for (int i = 0; i < N; i++) step(1, 8'(i), 0, 0, 0, 8'h00, 4'd0);
    endtask

    task automatic write_rand(input int n);
        for (int i = 0; i < n; i++) step(1, 8'($urandom), 0, 0, 0, 8'h00, 4'd0);
    endtask

    task automatic err_frame(input logic [3:0] ld);
        for (int i = 0; i < N; i++) step(0, 8'h00, 1, i == 0, loc_a[i], mag_a[i], ld);
    endtask

    task automatic clear_errs();
        for (int i = 0; i < N; i++) begin
            loc_a[i] = 0;
            mag_a[i] = '0;
        end
    endtask

    task automatic rand_errs(input int cnt);
        int c, p;
        clear_errs();
        c = 0;
        while (c < cnt) begin
            p = $urandom_range(0, N-1);
            if (!loc_a[p]) begin
                loc_a[p] = 1;
                mag_a[p] = 8'($urandom_range(1, 255));
                c++;
            end
        end
    endtask

    task automatic do_reset();
        rx_valid = 0; err_valid = 0; err_sof = 0; err_loc = 0;
        sys_rst_n = 0;
        #1;
        model_reset();
        chk("rst_corr_valid", corr_valid, 0);
        chk("rst_corr_data", corr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_count", err_count, 0);
        chk("rst_decode_fail", decode_fail, 0);
        chk("rst_overflow", overflow, 0);
        @(posedge clk_in);
        #1;
        sys_rst_n = 1;
    endtask

    initial begin
        int p, fd0, nerr;
        model_reset();
        fd_seen = 0;

        // Scenario 1: clean frame, ramp data
        do_reset();
        write_ramp();
        clear_errs();
        err_frame(4'd0);
        idle(2);
        chk("s1_count", last_cnt, 0);
        chk("s1_fail", last_fail, 0);

        // Scenario 2: three known corrections
        write_ramp();
        clear_errs();
        loc_a[3] = 1;   mag_a[3] = 8'h11;
        loc_a[50] = 1;  mag_a[50] = 8'hA5;
        loc_a[200] = 1; mag_a[200] = 8'hFF;
        err_frame(4'd3);
        idle(2);
        chk("s2_count", last_cnt, 3);
        chk("s2_fail", last_fail, 0);

        // Scenario 3: degree above t, then count/degree mismatch, then a zero-magnitude flag
        write_rand(N);
        rand_errs(9);
        err_frame(4'd9);
        idle(2);
        chk("s3a_count", last_cnt, 9);
        chk("s3a_fail", last_fail, 1);
        write_rand(N);
        rand_errs(3);
        err_frame(4'd4);
        idle(2);
        chk("s3b_fail", last_fail, 1);
        write_rand(N);
        rand_errs(5);
        for (int i = 0; i < N; i++) begin
            if (!loc_a[i]) begin
                loc_a[i] = 1;
                mag_a[i] = 8'h00;
                break;
            end
        end
        err_frame(4'd5);
        idle(2);
        chk("s3c_count", last_cnt, 5);
        chk("s3c_fail", last_fail, 0);

        // Scenario 4: two frames back-to-back on both sides
        for (int f = 0; f < 2; f++) begin
            nerr = 0;
            for (int i = 0; i < N; i++) begin
                loc_b[f*N+i] = ($urandom_range(0, 39) == 0);
                mag_b[f*N+i] = 8'($urandom_range(1, 255));
                if (loc_b[f*N+i]) nerr++;
            end
            lam_b[f] = (nerr > 8) ? 4'd8 : 4'(nerr);
        end
        fd0 = fd_seen;
        for (int c = 0; c < 2*N + 5; c++) begin
            p = c - 3;
            if (p >= 0 && p < 2*N)
                step(c < 2*N, 8'($urandom), 1, (p % N) == 0, loc_b[p], mag_b[p], lam_b[p / N]);
            else
                step(c < 2*N, 8'($urandom), 0, 0, 0, 8'h00, 4'd0);
        end
        idle(2);
        chk("s4_frames", fd_seen - fd0, 2);

        // Scenario 5: overflow, replay of the stored symbols, then underflow
        write_rand(513);
        chk("s5_overflow", overflow, 1);
        clear_errs();
        err_frame(4'd0);
        err_frame(4'd0);
        idle(2);
        chk("s5_replay_fail", last_fail, 0);
        err_frame(4'd0);
        idle(2);
        chk("s5_underflow_fail", last_fail, 1);

        // Scenario 6: reset in the middle of a frame, then a clean frame
        write_ramp();
        for (int i = 0; i < 100; i++) step(0, 8'h00, 1, i == 0, 0, 8'h00, 4'd0);
        do_reset();
        write_rand(N);
        rand_errs(2);
        err_frame(4'd2);
        idle(2);
        chk("s6_count", last_cnt, 2);
        chk("s6_fail", last_fail, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
